// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/target bus between hazard/branch logic and pc_sequencer.
// misalign_fault_o exists only when PC_MISALIGN_CHECK_EN is defined.
interface pc_sequencer_if #(parameter int N = 32);
  logic         pc_enable_i;
  logic         branch_taken_i;
  logic [N-1:0] branch_target_i;
  logic         jump_i;
  logic [N-1:0] jump_target_i;
  logic         eret_i;
  logic         exc_req_i;
  logic [N-1:0] exc_pc_i;
  logic [N-1:0] pc_value_o;
  logic [N-1:0] pc_plus_inc_o;
  logic [N-1:0] epc_o;
  logic         in_exception_o;
  logic         redirect_pending_o;
`ifdef PC_MISALIGN_CHECK_EN
  logic         misalign_fault_o;
  modport master (
    output pc_enable_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           eret_i, exc_req_i, exc_pc_i,
    input  pc_value_o, pc_plus_inc_o, epc_o, in_exception_o, redirect_pending_o,
           misalign_fault_o
  );
  modport slave (
    input  pc_enable_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           eret_i, exc_req_i, exc_pc_i,
    output pc_value_o, pc_plus_inc_o, epc_o, in_exception_o, redirect_pending_o,
           misalign_fault_o
  );
`else
  modport master (
    output pc_enable_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           eret_i, exc_req_i, exc_pc_i,
    input  pc_value_o, pc_plus_inc_o, epc_o, in_exception_o, redirect_pending_o
  );
  modport slave (
    input  pc_enable_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           eret_i, exc_req_i, exc_pc_i,
    output pc_value_o, pc_plus_inc_o, epc_o, in_exception_o, redirect_pending_o
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with next-PC selection, EPC and stall-held redirects.
// Defining PC_MISALIGN_CHECK_EN turns misaligned applied targets into internal exceptions.
module pc_sequencer #(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(32'h0040_0000),
  parameter logic [N-1:0] EXC_VECTOR   = N'(32'h8000_0180),
  parameter int           INC          = 4
) (
  input logic           clk_i,
  input logic           rst_ni,
  pc_sequencer_if.slave bus
);
  typedef enum logic {RUN, HOLD} state_e;
  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d, epc_q, epc_d, tgt_q, tgt_d;
  logic         exc_q, exc_d, tgt_eret_q, tgt_eret_d;
  logic         eret_ok, req, apply, apply_eret, misalign;
  logic [N-1:0] req_tgt, apply_tgt, pc_plus;
  // eret only counts while a handler is active; otherwise it is dropped entirely
  assign eret_ok    = bus.eret_i & exc_q;
  assign req        = eret_ok | bus.jump_i | bus.branch_taken_i;
  assign req_tgt    = eret_ok ? epc_q : bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
  assign apply      = bus.pc_enable_i & (req | (state_q == HOLD));
  assign apply_tgt  = req ? req_tgt : tgt_q;
  assign apply_eret = req ? eret_ok : tgt_eret_q;
  assign pc_plus    = pc_q + N'(INC);
`ifdef PC_MISALIGN_CHECK_EN
  logic fault_q;
  assign misalign = apply & ~bus.exc_req_i & (|apply_tgt[1:0]);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) fault_q <= 1'b0;
    else         fault_q <= misalign;
  assign bus.misalign_fault_o = fault_q;
`else
  assign misalign = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    exc_d      = exc_q;
    tgt_d      = tgt_q;
    tgt_eret_d = tgt_eret_q;
    if (bus.exc_req_i || misalign) begin
      pc_d    = EXC_VECTOR;
      exc_d   = 1'b1;
      epc_d   = exc_q ? epc_q : bus.exc_req_i ? bus.exc_pc_i : apply_tgt;
      state_d = RUN;
    end else if (bus.pc_enable_i) begin
      pc_d    = apply ? apply_tgt : pc_plus;
      exc_d   = exc_q & ~(apply & apply_eret);
      state_d = RUN;
    end else if (req) begin
      tgt_d      = req_tgt;
      tgt_eret_d = eret_ok;
      state_d    = HOLD;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      exc_q      <= 1'b0;
      tgt_q      <= '0;
      tgt_eret_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      exc_q      <= exc_d;
      tgt_q      <= tgt_d;
      tgt_eret_q <= tgt_eret_d;
    end
  assign bus.pc_value_o         = pc_q;
  assign bus.pc_plus_inc_o      = pc_plus;
  assign bus.epc_o              = epc_q;
  assign bus.in_exception_o     = exc_q;
  assign bus.redirect_pending_o = (state_q == HOLD);
endmodule
